fetch_unit: RTL and testbench

Instruction fetch stage feeding decode. It holds the PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returned words in a small FIFO. It hands instructions to decode over a valid/ready handshake. When the execute stage (branch_control's branch_taken, or a jump) signals a redirect, it restarts fetch at the target and discards all wrong-path instructions and in-flight responses.

---
 rtl/risc_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit_chk.sv | 25 ++
 rtl/fetch_unit.sv | 183 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared types and constants for the fetch stage and its consumers.
// FETCH_PERF_EN (see fetch_unit) has no effect on this package.
package risc_pkg;

  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Occupancy counters cover DEPTH up to 8 inclusive.
  localparam int                     FETCH_CNT_W = 4;
  localparam logic [FETCH_CNT_W-1:0] CNT_ZERO    = 4'd0;
  localparam logic [FETCH_CNT_W-1:0] CNT_ONE     = 4'd1;

  typedef struct packed {
    logic [31:0] pc;
    instr_t      instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between imem responses and decode: {pc, instr} entries,
// flush has priority over push/pop, head outputs read as zero while empty.
module fetch_fifo
  import risc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [31:0]            push_pc,
  input  logic [31:0]            push_instr,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [31:0]            head_pc,
  output logic [31:0]            head_instr,
  output logic [FETCH_CNT_W-1:0] count
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  fetch_entry_t           mem_r [DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [FETCH_CNT_W-1:0] count_r;

  // Storage, pointers and occupancy; pointers wrap at DEPTH, not at a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= '{pc: push_pc, instr: push_instr};
        wr_ptr_r        <= (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head view for decode.
  always_comb begin
    head_valid = (count_r != CNT_ZERO);
    count      = count_r;
    if (head_valid) begin
      head_pc    = mem_r[rd_ptr_r].pc;
      head_instr = mem_r[rd_ptr_r].instr;
    end else begin
      head_pc    = 32'h0000_0000;
      head_instr = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/fetch_unit_chk.sv
// Invariant checks for fetch_unit: buffer overflow and responses arriving
// with nothing outstanding (e.g. stale memory traffic across a reset).
module fetch_unit_chk
  import risc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_push,
  input  logic                   fifo_pop,
  input  logic [FETCH_CNT_W-1:0] fifo_count,
  input  logic                   rsp_valid,
  input  logic [FETCH_CNT_W-1:0] outstanding
);

  localparam logic [FETCH_CNT_W-1:0] DEPTH_CNT = FETCH_CNT_W'(DEPTH);

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && !fifo_pop && (fifo_count == DEPTH_CNT)));

  no_stray_response: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_valid && (outstanding == CNT_ZERO)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited in-order imem requests, response buffer.
// Define FETCH_PERF_EN to add perf_redirect_cnt / perf_stall_cnt.
module fetch_unit
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_redirect_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int                     PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]          PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [PW-1:0]          PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0]          PTR_ONE   = PW'(1);
  localparam logic [FETCH_CNT_W-1:0] DEPTH_CNT = FETCH_CNT_W'(DEPTH);

  fetch_state_e           state_r;
  fetch_state_e           state_nxt_s;
  logic [31:0]            pc_r;
  logic [FETCH_CNT_W-1:0] outstanding_r;
  logic [FETCH_CNT_W-1:0] discard_r;
  logic [FETCH_CNT_W-1:0] fifo_count_s;
  logic [FETCH_CNT_W-1:0] credits_s;
  logic [31:0]            tag_r [DEPTH];
  logic [PW-1:0]          tag_wr_r;
  logic [PW-1:0]          tag_rd_r;
  logic                   pop_s;
  logic                   rsp_s;
  logic                   push_s;
  logic                   accept_s;

  // Handshake qualifiers and the credit pool; discarded in-flight requests still hold credits.
  always_comb begin
    pop_s          = if_valid & id_ready & ~redirect_valid;
    rsp_s          = imem_rsp_valid & (outstanding_r != CNT_ZERO);
    push_s         = rsp_s & (discard_r == CNT_ZERO) & ~redirect_valid;
    credits_s      = DEPTH_CNT - outstanding_r - fifo_count_s + (pop_s ? CNT_ONE : CNT_ZERO);
    imem_req_valid = (state_r != BOOT) & (credits_s != CNT_ZERO) & ~redirect_valid;
    accept_s       = imem_req_valid & imem_req_ready;
    imem_req_addr  = pc_r;
  end

  // Next state: a redirect wins from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (redirect_valid) begin
      state_nxt_s = FLUSH;
    end else begin
      case (state_r)
        BOOT:    state_nxt_s = RUN;
        RUN:     state_nxt_s = RUN;
        FLUSH:   state_nxt_s = RUN;
        default: state_nxt_s = BOOT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // PC, outstanding and discard bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      discard_r     <= CNT_ZERO;
    end else begin
      if (redirect_valid) begin
        pc_r <= align_pc(redirect_pc);
      end else if (accept_s) begin
        pc_r <= pc_r + 32'd4;
      end
      case ({accept_s, rsp_s})
        2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
        2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
        default: outstanding_r <= outstanding_r;
      endcase
      if (redirect_valid) begin
        discard_r <= outstanding_r - (rsp_s ? CNT_ONE : CNT_ZERO);
      end else if (rsp_s && (discard_r != CNT_ZERO)) begin
        discard_r <= discard_r - CNT_ONE;
      end
    end
  end

  // PC tags of live requests, consumed only by responses that are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_r <= PTR_ZERO;
      tag_rd_r <= PTR_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i] <= 32'h0000_0000;
      end
    end else if (redirect_valid) begin
      tag_wr_r <= PTR_ZERO;
      tag_rd_r <= PTR_ZERO;
    end else begin
      if (accept_s) begin
        tag_r[tag_wr_r] <= pc_r;
        tag_wr_r        <= (tag_wr_r == PTR_LAST) ? PTR_ZERO : tag_wr_r + PTR_ONE;
      end
      if (push_s) begin
        tag_rd_r <= (tag_rd_r == PTR_LAST) ? PTR_ZERO : tag_rd_r + PTR_ONE;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_pc   (tag_r[tag_rd_r]),
    .push_instr(imem_rsp_data),
    .pop       (pop_s),
    .head_valid(if_valid),
    .head_pc   (if_pc),
    .head_instr(if_instr),
    .count     (fifo_count_s)
  );

  fetch_unit_chk #(
    .DEPTH(DEPTH)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_push  (push_s),
    .fifo_pop   (pop_s),
    .fifo_count (fifo_count_s),
    .rsp_valid  (imem_rsp_valid),
    .outstanding(outstanding_r)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirect_r;
  logic [31:0] perf_stall_r;

  // Event counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirect_r <= 32'h0000_0000;
      perf_stall_r    <= 32'h0000_0000;
    end else begin
      if (redirect_valid) begin
        perf_redirect_r <= perf_redirect_r + 32'd1;
      end
      if ((state_r == RUN) && !if_valid) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_redirect_cnt = perf_redirect_r;
  assign perf_stall_cnt    = perf_stall_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: fixed-latency in-order memory model and a
// program-order stream model for requested addresses and delivered instructions.
module tb_fetch_unit;
  import risc_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirect_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready)
`ifdef FETCH_PERF_EN
    , .perf_redirect_cnt(perf_redirect_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntotal = 0;
  int nfail = 0;
  int cyc, lat;
  logic [31:0] pq_addr [$];
  int          pq_due [$];
  logic [31:0] exp_req, exp_pc;
  int nacc, ndeliv, nredir, exp_stall;
  bit prev_redir;
  logic s_req_valid, s_if_valid;
  logic [31:0] s_req_addr;
  int first_req, first_v;
  bit armed;
  int arm_cyc;
  logic [31:0] arm_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: memory drives its due response, outputs are checked at negedge.
  task automatic cycle();
    if (pq_due.size() > 0 && pq_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    if (s_req_valid && first_req < 0) first_req = cyc;
    if (s_if_valid && first_v < 0) first_v = cyc;
    if (cyc >= 2 && !prev_redir && !if_valid) exp_stall++;
    if (imem_rsp_valid) begin
      void'(pq_addr.pop_front());
      void'(pq_due.pop_front());
    end
    if (redirect_valid) begin
      chk("req_withdrawn", {31'h0, imem_req_valid}, 32'h0);
      exp_req = redirect_pc & 32'hFFFF_FFFC;
      exp_pc  = exp_req;
      nredir++;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_req);
        pq_addr.push_back(exp_req);
        pq_due.push_back(cyc + lat);
        exp_req += 32'd4;
        nacc++;
      end
      if (if_valid) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_instr", if_instr, instr_of(exp_pc));
        if (id_ready) begin
          if (armed) begin
            armed   = 1'b0;
            arm_cyc = cyc;
            arm_pc  = if_pc;
          end
          exp_pc += 32'd4;
          ndeliv++;
        end
      end
    end
    chk("inflight_bound", {31'h0, pq_due.size() <= DEPTH}, 32'h1);
    prev_redir = redirect_valid;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    id_ready = 1'b0;
    pq_addr.delete();
    pq_due.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_redirect", perf_redirect_cnt, 32'h0);
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
`endif
    rst_n = 1'b1;
    cyc = 1;
    lat = l;
    exp_req = RST_PC;
    exp_pc = RST_PC;
    nacc = 0; ndeliv = 0; nredir = 0; exp_stall = 0;
    prev_redir = 1'b0;
    first_req = -1; first_v = -1;
    armed = 1'b0;
  endtask

  task automatic wait_armed(input int limit);
    for (int i = 0; i < limit && armed; i++) cycle();
    chk("deliver_timeout", {31'h0, armed}, 32'h0);
  endtask

  task automatic chk_perf();
`ifdef FETCH_PERF_EN
    chk("perf_redirect", perf_redirect_cnt, 32'(nredir));
    chk("perf_stall", perf_stall_cnt, 32'(exp_stall));
`endif
  endtask

  initial begin
    int n0, a0, nred;
    bit found;

    // Boot and sustained streaming
    do_reset(1);
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    repeat (15) cycle();
    chk("first_req_cycle", 32'(first_req), 32'd2);
    chk("first_valid_cycle", 32'(first_v), 32'd4);
    chk("throughput", 32'(ndeliv), 32'd12);

    // Decode stall fills the credit pool
    id_ready = 1'b0;
    repeat (10) cycle();
    chk("stall_req_valid", {31'h0, s_req_valid}, 32'h0);
    chk("stall_occupancy", 32'(nacc - ndeliv), 32'(DEPTH));
    n0 = ndeliv;
    id_ready = 1'b1;
    repeat (10) cycle();
    chk("resume_progress", {31'h0, (ndeliv - n0) >= 8}, 32'h1);

    // Memory not ready: address held
    do_reset(1);
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    repeat (3) cycle();
    imem_req_ready = 1'b0;
    repeat (3) begin
      cycle();
      chk("hold_valid", {31'h0, s_req_valid}, 32'h1);
      chk("hold_addr", s_req_addr, 32'h8);
    end
    imem_req_ready = 1'b1;
    a0 = nacc;
    cycle();
    chk("accept_addr", s_req_addr, 32'h8);
    chk("accept_now", 32'(nacc - a0), 32'h1);

    // Redirect with two responses in flight, 3-cycle memory
    do_reset(3);
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (pq_due.size() == 2 && pq_due[0] != cyc) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk("inflight_setup", {31'h0, found}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    armed = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    wait_armed(20);
    chk("redir_target", arm_pc, 32'h100);
    chk_perf();

    // Redirect coinciding with a response and a decode pop
    do_reset(1);
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pq_due.size() > 0 && pq_due[0] == cyc && if_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk("coincide_setup", {31'h0, found}, 32'h1);
    nred = cyc;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    armed = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("flush_empty", {31'h0, s_if_valid}, 32'h0);
    chk("target_req_valid", {31'h0, s_req_valid}, 32'h1);
    chk("target_req_addr", s_req_addr, 32'h200);
    wait_armed(10);
    chk("redir_latency", 32'(arm_cyc), 32'(nred + 3));
    chk("redir_pc_200", arm_pc, 32'h200);

    // Unaligned target, then back-to-back redirects
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk("unaligned_valid", {31'h0, s_req_valid}, 32'h1);
    chk("unaligned_addr", s_req_addr, 32'h100);
    repeat (3) cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    cycle();
    redirect_pc = 32'h400;
    armed = 1'b1;
    cycle();
    redirect_valid = 1'b0;
    wait_armed(10);
    chk("b2b_target", arm_pc, 32'h400);
    chk_perf();

    // Randomised traffic against the stream model
    do_reset(int'($urandom_range(1, 3)));
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = $urandom;
      end else begin
        redirect_valid = 1'b0;
      end
      cycle();
    end
    redirect_valid = 1'b0;
    chk("random_progress", {31'h0, ndeliv >= 40}, 32'h1);
    chk_perf();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
